// File: rtl/picorisc_pkg.sv
// Shared picoRISC control-unit definitions: address constants, branch types,
// error codes and sequencer FSM states.
package picorisc_pkg;

  localparam int AW = 8;
  localparam logic [AW-1:0] FETCH_ADDR = 8'd0;
  localparam logic [AW-1:0] TRAP_ADDR  = 8'd255;

  typedef enum logic [2:0] {
    BR_SEQ  = 3'd0,
    BR_JMP  = 3'd1,
    BR_JC   = 3'd2,
    BR_JNC  = 3'd3,
    BR_DOP  = 3'd4,
    BR_DADR = 3'd5,
    BR_CALL = 3'd6,
    BR_RET  = 3'd7
  } br_type_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BADMODE = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_UNF     = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/upc_stack.sv
// Micro-return LIFO for the sequencer. Push/pop requests are ignored when
// the stack is full/empty; the caller turns those cases into errors.
module upc_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  push_data,
  output logic [AW-1:0]  top,
  output logic           full,
  output logic           empty,
  output logic [SPW-1:0] sp
);
  import picorisc_pkg::*;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] cnt;
  logic [SPW-1:0] cnt_m1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[cnt[IW-1:0]] <= push_data;
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  // top is only meaningful when not empty; the wrapped index when empty is harmless
  always_comb begin
    cnt_m1 = cnt - 1'b1;
    top    = mem[cnt_m1[IW-1:0]];
    full   = (cnt == SPW'(DEPTH));
    empty  = (cnt == '0);
    sp     = cnt;
  end

endmodule

// File: rtl/micro_sequencer.sv
// picoRISC microprogram sequencer: selects the next control-store address
// from increment, branch, dispatch or return stack, with sticky error trapping.
module micro_sequencer #(
  parameter int              AW         = picorisc_pkg::AW,
  parameter int              NCOND      = 8,
  parameter int              DEPTH      = 4,
  parameter logic [AW-1:0]   FETCH_ADDR = picorisc_pkg::FETCH_ADDR,
  parameter logic [AW-1:0]   TRAP_ADDR  = picorisc_pkg::TRAP_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       br_type,
  input  logic [2:0]       cond_sel,
  input  logic [AW-1:0]    br_target,
  input  logic [NCOND-1:0] cond_vec,
  input  logic [AW-1:0]    kmop_addr,
  input  logic [AW-1:0]    kmadr_addr,
  input  logic             clr_err,
  output logic [AW-1:0]    upc,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [2:0]       sp
);
  import picorisc_pkg::*;

  seq_state_e    state, state_next;
  logic          advance;
  logic [AW-1:0] upc_inc, upc_next, stk_top;
  logic          push, pop, stk_full, stk_empty;
  logic          new_err;
  logic [1:0]    new_code;
  logic          cond_bit;
  br_type_e      br;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      ST_RESET: begin
        state_next = ST_RUN;
        advance    = !stall;
      end
      ST_RUN: begin
        if (stall) state_next = ST_HOLD;
        advance = !stall;
      end
      ST_HOLD: begin
        if (!stall) state_next = ST_RUN;
        advance = !stall;
      end
      default: state_next = ST_RESET;
    endcase
  end

  // Next-address mux; error cases override the target with the trap vector
  always_comb begin
    br       = br_type_e'(br_type);
    upc_inc  = upc + 1'b1;
    cond_bit = cond_vec[cond_sel];
    upc_next = upc_inc;
    push     = 1'b0;
    pop      = 1'b0;
    new_err  = 1'b0;
    new_code = ERR_NONE;
    case (br)
      BR_SEQ:  upc_next = upc_inc;
      BR_JMP:  upc_next = br_target;
      BR_JC:   upc_next = cond_bit ? br_target : upc_inc;
      BR_JNC:  upc_next = cond_bit ? upc_inc : br_target;
      BR_DOP:  upc_next = kmop_addr;
      BR_DADR: begin
        if (kmadr_addr == '0) begin
          new_err  = 1'b1;
          new_code = ERR_BADMODE;
        end else begin
          upc_next = kmadr_addr;
        end
      end
      BR_CALL: begin
        if (stk_full) begin
          new_err  = 1'b1;
          new_code = ERR_OVF;
        end else begin
          push     = advance;
          upc_next = br_target;
        end
      end
      BR_RET: begin
        if (stk_empty) begin
          new_err  = 1'b1;
          new_code = ERR_UNF;
        end else begin
          pop      = advance;
          upc_next = stk_top;
        end
      end
      default: upc_next = upc_inc;
    endcase
    if (new_err) upc_next = TRAP_ADDR;
  end

  upc_stack #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .SPW   (3)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (upc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .sp        (sp)
  );

  // A fresh error takes priority over a coincident clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upc      <= FETCH_ADDR;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (advance) begin
      upc <= upc_next;
      if (new_err) begin
        err      <= 1'b1;
        err_code <= new_code;
      end else if (clr_err) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed test-plan steps with literal
// expectations, then randomized traffic against a queue-based behavioural model.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] br_type = 3'd0;
  logic [2:0] cond_sel = 3'd0;
  logic [7:0] br_target = 8'd0;
  logic [7:0] cond_vec = 8'd0;
  logic [7:0] kmop_addr = 8'd0;
  logic [7:0] kmadr_addr = 8'd0;
  logic       clr_err = 1'b0;
  logic [7:0] upc;
  logic       err;
  logic [1:0] err_code;
  logic [2:0] sp;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  logic [7:0] mUpc = 8'd0;
  bit         mErr = 1'b0;
  logic [1:0] mCode = 2'd0;
  logic [7:0] stk[$];

  micro_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_type    (br_type),
    .cond_sel   (cond_sel),
    .br_target  (br_target),
    .cond_vec   (cond_vec),
    .kmop_addr  (kmop_addr),
    .kmadr_addr (kmadr_addr),
    .clr_err    (clr_err),
    .upc        (upc),
    .err        (err),
    .err_code   (err_code),
    .sp         (sp)
  );

  always #5 clk = ~clk;

  // Reference behaviour straight from the sequencing rules, using a queue as the stack
  task automatic modelStep;
    logic [7:0] nxt;
    bit         e;
    logic [1:0] c;
    if (!rst_n) begin
      mUpc = 8'd0;
      stk.delete();
      mErr = 1'b0;
      mCode = 2'd0;
    end else if (!stall) begin
      nxt = mUpc + 8'd1;
      e = 1'b0;
      c = 2'd0;
      case (br_type)
        3'd1: nxt = br_target;
        3'd2: if (cond_vec[cond_sel]) nxt = br_target;
        3'd3: if (!cond_vec[cond_sel]) nxt = br_target;
        3'd4: nxt = kmop_addr;
        3'd5: if (kmadr_addr == 8'd0) begin e = 1'b1; c = 2'd1; end
              else nxt = kmadr_addr;
        3'd6: if (stk.size() == 4) begin e = 1'b1; c = 2'd2; end
              else begin stk.push_back(nxt); nxt = br_target; end
        3'd7: if (stk.size() == 0) begin e = 1'b1; c = 2'd3; end
              else nxt = stk.pop_back();
        default: ;
      endcase
      if (e) begin
        nxt = 8'd255;
        mErr = 1'b1;
        mCode = c;
      end else if (clr_err) begin
        mErr = 1'b0;
        mCode = 2'd0;
      end
      mUpc = nxt;
    end
  endtask

  task automatic applyStimulus(input bit rn, input bit stl, input logic [2:0] bt,
                               input logic [2:0] cs, input logic [7:0] tgt,
                               input logic [7:0] cv, input logic [7:0] kop,
                               input logic [7:0] kadr, input bit clr);
    rst_n = rn; stall = stl; br_type = bt; cond_sel = cs; br_target = tgt;
    cond_vec = cv; kmop_addr = kop; kmadr_addr = kadr; clr_err = clr;
    @(posedge clk);
    modelStep();
    checkEn = 1'b1;
    #1;
  endtask

  task automatic op(input logic [2:0] bt, input logic [7:0] tgt);
    applyStimulus(1'b1, 1'b0, bt, 3'd0, tgt, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input int eUpc, input int eSp,
                             input int eErr, input int eCode);
    checks += 4;
    if (upc !== eUpc[7:0]) begin
      errors++; $display("[TB] FAIL %s upc actual=%0d required=%0d", name, upc, eUpc);
    end
    if (sp !== eSp[2:0]) begin
      errors++; $display("[TB] FAIL %s sp actual=%0d required=%0d", name, sp, eSp);
    end
    if (err !== eErr[0]) begin
      errors++; $display("[TB] FAIL %s err actual=%0d required=%0d", name, err, eErr);
    end
    if (err_code !== eCode[1:0]) begin
      errors++; $display("[TB] FAIL %s err_code actual=%0d required=%0d", name, err_code, eCode);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must agree with the model
  always @(negedge clk) begin
    if (checkEn) begin
      checks += 4;
      if (upc !== mUpc) begin
        errors++; $display("[TB] FAIL model_upc actual=%0d required=%0d at %0t", upc, mUpc, $time);
      end
      if (sp !== 3'(stk.size())) begin
        errors++; $display("[TB] FAIL model_sp actual=%0d required=%0d at %0t", sp, stk.size(), $time);
      end
      if (err !== mErr) begin
        errors++; $display("[TB] FAIL model_err actual=%0d required=%0d at %0t", err, mErr, $time);
      end
      if (err_code !== mCode) begin
        errors++; $display("[TB] FAIL model_code actual=%0d required=%0d at %0t", err_code, mCode, $time);
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("reset", 0, 0, 0, 0);

    op(3'd0, 8'd0); checkOutput("seq1", 1, 0, 0, 0);
    op(3'd0, 8'd0); checkOutput("seq2", 2, 0, 0, 0);
    op(3'd0, 8'd0); checkOutput("seq3", 3, 0, 0, 0);
    op(3'd1, 8'd255); checkOutput("jmp255", 255, 0, 0, 0);
    op(3'd0, 8'd0); checkOutput("wrap", 0, 0, 0, 0);

    op(3'd1, 8'd5);
    applyStimulus(1'b1, 1'b0, 3'd2, 3'd2, 8'd40, 8'b0000_0100, 8'd0, 8'd0, 1'b0);
    checkOutput("jc_taken", 40, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 3'd2, 3'd2, 8'd90, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("jc_not", 41, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 3'd3, 3'd2, 8'd90, 8'b0000_0100, 8'd0, 8'd0, 1'b0);
    checkOutput("jnc_not", 42, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 3'd3, 3'd2, 8'd40, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("jnc_taken", 40, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 3'd4, 3'd0, 8'd0, 8'd0, 8'd77, 8'd0, 1'b0);
    checkOutput("dop", 77, 0, 0, 0);

    applyStimulus(1'b1, 1'b0, 3'd5, 3'd0, 8'd0, 8'd0, 8'd0, 8'd19, 1'b0);
    checkOutput("dadr", 19, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 3'd5, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("dadr_bad", 255, 0, 1, 1);
    op(3'd0, 8'd0); checkOutput("err_sticky", 0, 0, 1, 1);
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    checkOutput("clr_err", 1, 0, 0, 0);

    op(3'd1, 8'd10);
    op(3'd6, 8'd50); checkOutput("call1", 50, 1, 0, 0);
    op(3'd6, 8'd80); checkOutput("call2", 80, 2, 0, 0);
    op(3'd7, 8'd0);  checkOutput("ret1", 51, 1, 0, 0);
    op(3'd7, 8'd0);  checkOutput("ret2", 11, 0, 0, 0);

    for (int i = 1; i <= 4; i++) begin
      op(3'd6, 8'd100); checkOutput("call_fill", 100, i, 0, 0);
    end
    op(3'd6, 8'd100); checkOutput("call_ovf", 255, 4, 1, 2);
    applyStimulus(1'b1, 1'b0, 3'd5, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    checkOutput("err_beats_clr", 255, 4, 1, 1);

    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("reset2", 0, 0, 0, 0);
    op(3'd7, 8'd0); checkOutput("ret_unf", 255, 0, 1, 3);
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);

    op(3'd1, 8'd10);
    op(3'd6, 8'd60);
    op(3'd6, 8'd60); checkOutput("pre_stall", 60, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd6, 3'd0, 8'd70, 8'd0, 8'd0, 8'd0, 1'b0);
      checkOutput("stalled", 60, 2, 0, 0);
    end
    op(3'd6, 8'd70); checkOutput("stall_release", 70, 3, 0, 0);
    applyStimulus(1'b0, 1'b0, 3'd6, 3'd0, 8'd70, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("reset_mid", 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      automatic bit         rn  = ($urandom_range(0, 49) != 0);
      automatic bit         stl = ($urandom_range(0, 3) == 0);
      automatic logic [2:0] bt  = 3'($urandom_range(0, 7));
      automatic logic [7:0] ka  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      applyStimulus(rn, stl, bt, 3'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), ka, ($urandom_range(0, 4) == 0));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
